// File: rtl/sr_bank_pkg.sv
// Shared types and constants for the SR bank sequencer.
package sr_bank_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PULSE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_VERIFY = 3'd3,
        ST_ACK    = 3'd4
    } state_e;

    localparam logic OP_SET = 1'b1;
    localparam logic OP_RST = 1'b0;

endpackage

// File: rtl/sr_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, pointer moves to the loser
// whenever a grant is taken.
module sr_rr_arb2
    import sr_bank_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

    logic ptr_q;

    // Pointer breaks ties only; a single requester always wins outright.
    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = ptr_q ? 2'b10 : 2'b01;
        end
    end

    // After each grant the other requester gets priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else if (en_i && (|req_i)) begin
            ptr_q <= gnt_o[0];
        end
    end

endmodule

// File: rtl/sr_bank_ctrl.sv
// SR flip-flop bank sequencer: arbitrates two requesters, issues one-hot
// set/reset pulses, settles, acknowledges and tracks a shadow of the bank.
// Optional read-back verify step enabled by defining SR_BANK_VERIFY_EN.
//
// state     | meaning
// ST_IDLE   | waiting for a request; arbitrate and latch winner
// ST_PULSE  | s or r driven on the target bit for PULSE_W cycles
// ST_SETTLE | s=r=0 for SETTLE cycles
// ST_VERIFY | compare q_fb against the requested value (SR_BANK_VERIFY_EN)
// ST_ACK    | ack pulse to the winner, then back to idle
module sr_bank_ctrl
    import sr_bank_pkg::*;
#(
    parameter int N       = 8,
    parameter int IW      = (N > 1) ? $clog2(N) : 1,
    parameter int PULSE_W = 2,
    parameter int SETTLE  = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    input  logic [IW-1:0] req0_idx,
    input  logic          req0_op,
    output logic          req0_ack,
    input  logic          req1_valid,
    input  logic [IW-1:0] req1_idx,
    input  logic          req1_op,
    output logic          req1_ack,
    output logic [N-1:0]  s,
    output logic [N-1:0]  r,
    input  logic [N-1:0]  q_fb,
    output logic [N-1:0]  shadow,
    output logic          busy,
    output logic          err
);

    localparam logic [IW:0] N_L = (IW + 1)'(N);

    state_e        state_q;
    logic [15:0]   cnt_q;
    logic [N-1:0]  s_q, r_q, shadow_q;
    logic          ack_q, sel_q, op_q;
    logic [IW-1:0] idx_q;

    logic [1:0]    gnt;
    logic          win_sel, cmd_op, in_range, noop;
    logic [IW-1:0] cmd_idx;
    logic [N-1:0]  cmd_oh;

    sr_rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i ({req1_valid, req0_valid}),
        .en_i  (state_q == ST_IDLE),
        .gnt_o (gnt)
    );

    // Winner's command and whether it would change the bank at all.
    always_comb begin
        win_sel  = gnt[1];
        cmd_idx  = win_sel ? req1_idx : req0_idx;
        cmd_op   = win_sel ? req1_op  : req0_op;
        in_range = ({1'b0, cmd_idx} < N_L);
        noop     = !in_range || (cmd_op == shadow_q[cmd_idx]);
        cmd_oh   = {{(N-1){1'b0}}, 1'b1} << cmd_idx;
    end

    // Sequencer FSM with registered s/r/ack/shadow outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            s_q      <= '0;
            r_q      <= '0;
            shadow_q <= '0;
            ack_q    <= 1'b0;
            sel_q    <= 1'b0;
            op_q     <= 1'b0;
            idx_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|gnt) begin
                        sel_q <= win_sel;
                        idx_q <= cmd_idx;
                        op_q  <= cmd_op;
                        if (noop) begin
                            // ACK entered with ack low gives the extra cycle of no-op timing.
                            state_q <= ST_ACK;
                        end else begin
                            state_q <= ST_PULSE;
                            cnt_q   <= 16'(PULSE_W - 1);
                            s_q     <= cmd_op ? cmd_oh : '0;
                            r_q     <= cmd_op ? '0 : cmd_oh;
                        end
                    end
                end
                ST_PULSE: begin
                    if (cnt_q == '0) begin
                        s_q <= '0;
                        r_q <= '0;
                        if (SETTLE > 0) begin
                            state_q <= ST_SETTLE;
                            cnt_q   <= 16'(SETTLE - 1);
                        end else begin
`ifdef SR_BANK_VERIFY_EN
                            state_q <= ST_VERIFY;
`else
                            state_q         <= ST_ACK;
                            ack_q           <= 1'b1;
                            shadow_q[idx_q] <= op_q;
`endif
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == '0) begin
`ifdef SR_BANK_VERIFY_EN
                        state_q <= ST_VERIFY;
`else
                        state_q         <= ST_ACK;
                        ack_q           <= 1'b1;
                        shadow_q[idx_q] <= op_q;
`endif
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
`ifdef SR_BANK_VERIFY_EN
                ST_VERIFY: begin
                    state_q         <= ST_ACK;
                    ack_q           <= 1'b1;
                    shadow_q[idx_q] <= q_fb[idx_q];
                end
`endif
                ST_ACK: begin
                    if (!ack_q) begin
                        ack_q <= 1'b1;
                    end else begin
                        ack_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef SR_BANK_VERIFY_EN
    logic err_q;

    // Sticky read-back mismatch flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (state_q == ST_VERIFY && q_fb[idx_q] != op_q) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_q_fb;
    assign unused_q_fb = ^q_fb;
    assign err         = 1'b0;
`endif

    assign s        = s_q;
    assign r        = r_q;
    assign shadow   = shadow_q;
    assign req0_ack = ack_q & ~sel_q;
    assign req1_ack = ack_q &  sel_q;
    assign busy     = (state_q != ST_IDLE);

endmodule
